// File: rtl/sfft_pkg.sv
// Shared defaults, FSM encoding and the twiddle quantisation helper for the
// sliding-DFT engine and its twiddle table.
package sfft_pkg;

  localparam int NFFT_DEF        = 8;
  localparam int NFFT_LOG2_DEF   = 3;
  localparam int INPUT_WIDTH_DEF = 24;
  localparam int ACC_WIDTH_DEF   = 32;
  localparam int TW_WIDTH_DEF    = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELTA  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  // Round to nearest with ties away from zero; evaluated only at elaboration.
  function automatic int round_nearest(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

endpackage

// File: rtl/sdft_twiddle_rom.sv
// Combinational twiddle table: (cos, sin)(2*pi*k/NFFT) for k = 0..NFFT/2-1,
// rounded to nearest in Q2.(TW_WIDTH-2).
module sdft_twiddle_rom
  import sfft_pkg::*;
#(
  parameter int NFFT      = NFFT_DEF,
  parameter int NFFT_LOG2 = NFFT_LOG2_DEF,
  parameter int TW_WIDTH  = TW_WIDTH_DEF
) (
  input  logic        [NFFT_LOG2-2:0] k,
  output logic signed [TW_WIDTH-1:0]  cos_val,
  output logic signed [TW_WIDTH-1:0]  sin_val
);

  localparam int  NUM_BINS = NFFT / 2;
  localparam real PI       = 3.14159265358979323846;
  localparam real ONE      = real'(1 << (TW_WIDTH - 2));

  logic signed [TW_WIDTH-1:0] cos_tab [NUM_BINS];
  logic signed [TW_WIDTH-1:0] sin_tab [NUM_BINS];

  // The angle pi/2 lands on a tiny nonzero cosine that rounds to exactly zero.
  for (genvar g = 0; g < NUM_BINS; g++) begin : g_tab
    localparam real ANG   = 2.0 * PI * real'(g) / real'(NFFT);
    localparam int  C_INT = round_nearest(ONE * $cos(ANG));
    localparam int  S_INT = round_nearest(ONE * $sin(ANG));
    assign cos_tab[g] = TW_WIDTH'(C_INT);
    assign sin_tab[g] = TW_WIDTH'(S_INT);
  end

  assign cos_val = cos_tab[k];
  assign sin_val = sin_tab[k];

endmodule

// File: rtl/sliding_dft_engine.sv
// Recursive sliding DFT: each accepted sample updates NFFT/2 complex bins,
// one bin per clock, and streams every updated bin out.
module sliding_dft_engine
  import sfft_pkg::*;
#(
  parameter int NFFT        = NFFT_DEF,
  parameter int NFFT_LOG2   = NFFT_LOG2_DEF,
  parameter int INPUT_WIDTH = INPUT_WIDTH_DEF,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int TW_WIDTH    = TW_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [INPUT_WIDTH-1:0] in_sample,
  output logic                          out_valid,
  output logic        [NFFT_LOG2-2:0]   out_bin,
  output logic signed [ACC_WIDTH-1:0]   out_re,
  output logic signed [ACC_WIDTH-1:0]   out_im,
  output logic                          out_last,
  output logic                          window_full
);

  localparam int NUM_BINS = NFFT / 2;
  localparam int KW       = NFFT_LOG2 - 1;
  localparam int SHIFT    = TW_WIDTH - 2;
  // (re + delta) needs one guard bit; the complex sum needs one more.
  localparam int PW       = ACC_WIDTH + TW_WIDTH + 2;

  localparam logic [KW-1:0]          K_LAST   = KW'(NUM_BINS - 1);
  localparam logic [NFFT_LOG2:0]     CNT_FULL = (NFFT_LOG2 + 1)'(NFFT);
  localparam logic signed [PW-1:0]   ACC_MAX  = {{(PW - ACC_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic signed [PW-1:0]   ACC_MIN  = ~ACC_MAX;

  state_t                         state;
  logic        [NFFT_LOG2-1:0]    wr_ptr;
  logic        [NFFT_LOG2:0]      sample_cnt;
  logic        [KW-1:0]           bin_idx;
  logic signed [INPUT_WIDTH-1:0]  x_new;
  logic signed [ACC_WIDTH-1:0]    delta;
  logic                           sat_flag;

  logic signed [INPUT_WIDTH-1:0]  delay_line [NFFT];
  logic signed [ACC_WIDTH-1:0]    re_mem     [NUM_BINS];
  logic signed [ACC_WIDTH-1:0]    im_mem     [NUM_BINS];

  logic signed [TW_WIDTH-1:0]     cos_val;
  logic signed [TW_WIDTH-1:0]     sin_val;
  logic signed [ACC_WIDTH:0]      t_re;
  logic signed [PW-1:0]           prod_re;
  logic signed [PW-1:0]           prod_im;
  logic signed [PW-1:0]           shr_re;
  logic signed [PW-1:0]           shr_im;
  logic signed [ACC_WIDTH-1:0]    new_re;
  logic signed [ACC_WIDTH-1:0]    new_im;
  logic                           sat_re;
  logic                           sat_im;

  sdft_twiddle_rom #(
    .NFFT      (NFFT),
    .NFFT_LOG2 (NFFT_LOG2),
    .TW_WIDTH  (TW_WIDTH)
  ) u_twiddle (
    .k       (bin_idx),
    .cos_val (cos_val),
    .sin_val (sin_val)
  );

  // NOTE: combinational logic uses blocking '=' so each line sees the value
  // computed just above it; registered state below uses '<=' only.
  always_comb begin
    // NOTE: every output of this block is assigned unconditionally first, so
    // no path can leave a value held and no latch is inferred.
    sat_re  = 1'b0;
    sat_im  = 1'b0;
    t_re    = (ACC_WIDTH + 1)'(re_mem[bin_idx]) + (ACC_WIDTH + 1)'(delta);
    prod_re = PW'(t_re) * PW'(cos_val) - PW'(im_mem[bin_idx]) * PW'(sin_val);
    prod_im = PW'(t_re) * PW'(sin_val) + PW'(im_mem[bin_idx]) * PW'(cos_val);
    shr_re  = prod_re >>> SHIFT;
    shr_im  = prod_im >>> SHIFT;
    new_re  = shr_re[ACC_WIDTH-1:0];
    new_im  = shr_im[ACC_WIDTH-1:0];

    if (shr_re > ACC_MAX) begin
      new_re = ACC_MAX[ACC_WIDTH-1:0];
      sat_re = 1'b1;
    end else if (shr_re < ACC_MIN) begin
      new_re = ACC_MIN[ACC_WIDTH-1:0];
      sat_re = 1'b1;
    end

    if (shr_im > ACC_MAX) begin
      new_im = ACC_MAX[ACC_WIDTH-1:0];
      sat_im = 1'b1;
    end else if (shr_im < ACC_MIN) begin
      new_im = ACC_MIN[ACC_WIDTH-1:0];
      sat_im = 1'b1;
    end
  end

  // NOTE: the delay line and bins are flip-flop arrays rather than RAM because
  // both reset and clear must zero every entry on a single edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_bin     <= '0;
      out_re      <= '0;
      out_im      <= '0;
      window_full <= 1'b0;
      wr_ptr      <= '0;
      sample_cnt  <= '0;
      bin_idx     <= '0;
      x_new       <= '0;
      delta       <= '0;
      sat_flag    <= 1'b0;
      for (int i = 0; i < NFFT; i++)     delay_line[i] <= '0;
      for (int i = 0; i < NUM_BINS; i++) re_mem[i]     <= '0;
      for (int i = 0; i < NUM_BINS; i++) im_mem[i]     <= '0;
    end else if (clear) begin
      // Saturation history survives a clear; only reset forgets it.
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_bin     <= '0;
      out_re      <= '0;
      out_im      <= '0;
      window_full <= 1'b0;
      wr_ptr      <= '0;
      sample_cnt  <= '0;
      bin_idx     <= '0;
      x_new       <= '0;
      delta       <= '0;
      for (int i = 0; i < NFFT; i++)     delay_line[i] <= '0;
      for (int i = 0; i < NUM_BINS; i++) re_mem[i]     <= '0;
      for (int i = 0; i < NUM_BINS; i++) im_mem[i]     <= '0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_new    <= in_sample;
            in_ready <= 1'b0;
            state    <= S_DELTA;
          end
        end

        S_DELTA: begin
          delay_line[wr_ptr] <= x_new;
          delta              <= ACC_WIDTH'(x_new) - ACC_WIDTH'(delay_line[wr_ptr]);
          wr_ptr             <= wr_ptr + 1'b1;
          if (sample_cnt != CNT_FULL) sample_cnt <= sample_cnt + 1'b1;
          bin_idx            <= '0;
          state              <= S_UPDATE;
        end

        S_UPDATE: begin
          re_mem[bin_idx] <= new_re;
          im_mem[bin_idx] <= new_im;
          out_valid       <= 1'b1;
          out_bin         <= bin_idx;
          out_re          <= new_re;
          out_im          <= new_im;
          sat_flag        <= sat_flag | sat_re | sat_im;
          // Flag the full window alongside bin 0 of the frame that filled it.
          if (bin_idx == '0 && sample_cnt == CNT_FULL) window_full <= 1'b1;
          if (bin_idx == K_LAST) begin
            out_last <= 1'b1;
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end else begin
            bin_idx <= bin_idx + 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sliding_dft_engine.sv
// Directed bench for sliding_dft_engine (NFFT=8, ACC_WIDTH=24): impulse, window
// fill/slide, back-to-back handshake, clear, reset abort and saturation.
module tb_sliding_dft_engine;

  localparam int NB = 4;
  localparam int AW = 24;

  logic                 clk;
  logic                 reset;
  logic                 clear;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [23:0]   in_sample;
  logic                 out_valid;
  logic        [1:0]    out_bin;
  logic signed [AW-1:0] out_re;
  logic signed [AW-1:0] out_im;
  logic                 out_last;
  logic                 window_full;

  sliding_dft_engine #(
    .NFFT        (8),
    .NFFT_LOG2   (3),
    .INPUT_WIDTH (24),
    .ACC_WIDTH   (AW),
    .TW_WIDTH    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sample   (in_sample),
    .out_valid   (out_valid),
    .out_bin     (out_bin),
    .out_re      (out_re),
    .out_im      (out_im),
    .out_last    (out_last),
    .window_full (window_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [23:0] sample;
    longint             bin0;
    logic               wf_pre;
    logic               wf;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic signed [AW-1:0] fr_re [NB];
  logic signed [AW-1:0] fr_im [NB];
  logic                 fr_wf [NB];
  logic                 wf_pre;

  // Impulse of 100: bin k = 100 * e^{j*2*pi*k/8}, floor after the Q2.14 scale.
  longint imp_re [NB] = '{100, 70, 0, -71};
  longint imp_im [NB] = '{0, 70, 100, 70};

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_frame(input logic signed [23:0] s);
    @(negedge clk);
    check("pre_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_sample = s;
    @(negedge clk);
    in_valid  = 1'b0;
    in_sample = ~s;
    check("delta_valid", out_valid, 0);
    check("delta_ready", in_ready, 0);
    @(negedge clk);
    check("upd_valid", out_valid, 0);
    wf_pre = window_full;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      check($sformatf("bin%0d_valid", k), out_valid, 1);
      check($sformatf("bin%0d_index", k), out_bin, k);
      check($sformatf("bin%0d_last", k), out_last, (k == NB - 1) ? 1 : 0);
      check($sformatf("bin%0d_ready", k), in_ready, (k == NB - 1) ? 1 : 0);
      fr_re[k] = out_re;
      fr_im[k] = out_im;
      fr_wf[k] = window_full;
    end
  endtask

  task automatic check_impulse(input string tag);
    for (int k = 0; k < NB; k++) begin
      check($sformatf("%s_re%0d", tag, k), fr_re[k], imp_re[k]);
      check($sformatf("%s_im%0d", tag, k), fr_im[k], imp_im[k]);
    end
    check($sformatf("%s_wf", tag), fr_wf[0], 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic count_outputs(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (out_valid) n++;
    end
  endtask

  initial begin
    vec_t   tab [10];
    int     n;
    int     idx;
    int     nfr;
    logic   pend;
    int     acc_c [5];
    longint got   [8];
    logic signed [23:0] s5 [5];
    longint e5 [5];

    tab[0] = '{24'sd61, 61,  1'b0, 1'b0};
    tab[1] = '{24'sd77, 138, 1'b0, 1'b0};
    tab[2] = '{24'sd90, 228, 1'b0, 1'b0};
    tab[3] = '{24'sd6,  234, 1'b0, 1'b0};
    tab[4] = '{24'sd33, 267, 1'b0, 1'b0};
    tab[5] = '{24'sd23, 290, 1'b0, 1'b0};
    tab[6] = '{24'sd85, 375, 1'b0, 1'b0};
    tab[7] = '{24'sd11, 386, 1'b0, 1'b1};
    tab[8] = '{24'sd0,  325, 1'b1, 1'b1};
    tab[9] = '{24'sd50, 298, 1'b1, 1'b1};
    s5 = '{24'sd10, 24'sd20, 24'sd30, 24'sd40, 24'sd50};
    e5 = '{10, 30, 60, 100, 150};

    clk = 1'b0; reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_sample = '0;

    // Reset state and quiet idle.
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_bin", out_bin, 0);
    check("rst_re", out_re, 0);
    check("rst_im", out_im, 0);
    check("rst_wf", window_full, 0);
    reset = 1'b1;
    count_outputs(20, n);
    check("idle_no_output", n, 0);
    check("idle_ready", in_ready, 1);

    // Impulse response.
    do_frame(24'sd100);
    check_impulse("imp");

    // Window fill, then slide past the wrap of the write pointer.
    pulse_clear();
    for (int i = 0; i < 10; i++) begin
      do_frame(tab[i].sample);
      check($sformatf("win%0d_bin0_re", i), fr_re[0], tab[i].bin0);
      check($sformatf("win%0d_bin0_im", i), fr_im[0], 0);
      check($sformatf("win%0d_wf_pre", i), wf_pre, tab[i].wf_pre);
      check($sformatf("win%0d_wf", i), fr_wf[0], tab[i].wf);
      check($sformatf("win%0d_wf_last", i), fr_wf[NB-1], tab[i].wf);
    end

    // Clear in the middle of an update pass.
    @(negedge clk);
    in_valid = 1'b1; in_sample = 24'sd123;
    @(negedge clk);
    in_valid = 1'b0; in_sample = '0;
    @(negedge clk);
    @(negedge clk);
    check("mid_bin0_valid", out_valid, 1);
    check("mid_wf_before", window_full, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_valid", out_valid, 0);
    check("clr_wf", window_full, 0);
    check("clr_ready", in_ready, 1);
    // A sample offered together with clear is dropped.
    clear = 1'b1; in_valid = 1'b1; in_sample = 24'sd555;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; in_sample = '0;
    count_outputs(8, n);
    check("clr_drop_no_output", n, 0);
    do_frame(24'sd100);
    check_impulse("reimp");

    // in_valid held high across five back-to-back samples.
    pulse_clear();
    idx = 0; nfr = 0; pend = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (out_valid && out_bin == 2'd0 && nfr < 8) begin
        got[nfr] = out_re;
        nfr++;
      end
      if (pend) begin
        idx++;
        if (idx < 5) in_sample = s5[idx];
        else in_valid = 1'b0;
      end
      if (c == 0) begin
        in_valid  = 1'b1;
        in_sample = s5[0];
      end
      pend = in_valid && in_ready;
      if (pend) acc_c[idx] = c;
    end
    in_valid = 1'b0;
    check("busy_accepts", idx, 5);
    check("busy_frames", nfr, 5);
    for (int i = 0; i < 5; i++) check($sformatf("busy_bin0_%0d", i), got[i], e5[i]);
    for (int i = 0; i < 4; i++) check($sformatf("busy_gap_%0d", i), acc_c[i+1] - acc_c[i], 6);

    // Asynchronous reset during an update pass aborts the frame.
    @(negedge clk);
    in_valid = 1'b1; in_sample = 24'sd77;
    @(negedge clk);
    in_valid = 1'b0; in_sample = '0;
    repeat (3) @(negedge clk);
    check("arst_pre_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_wf", window_full, 0);
    @(negedge clk);
    reset = 1'b1;
    count_outputs(8, n);
    check("arst_no_output", n, 0);

    // Full-scale samples: bin 0 clamps at the positive limit and never wraps.
    for (int f = 0; f < 10; f++) begin
      do_frame(24'sh7FFFFF);
      check($sformatf("sat_bin0_%0d", f), fr_re[0], 8388607);
      if (f == 0) check("sat_flag_after_first", dut.sat_flag, 0);
    end
    check("sat_flag_set", dut.sat_flag, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
